// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM states, the IF/ID
// latch layout and the halt encoding.
package fetch_unit_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } fetch_latch_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer that parks a fetched word while decode is stalled,
// remembering whether that word was the halt instruction.
module fetch_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic         CLK,
  input  logic         nRST,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  fetch_latch_t wr_entry,
  input  logic         wr_is_halt,
  output fetch_latch_t entry,
  output logic         is_halt
);

  fetch_latch_t entry_r;
  logic         is_halt_r;

  // Buffer storage; drain and clear both empty it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      entry_r   <= '0;
      is_halt_r <= 1'b0;
    end else if (clear || drain) begin
      entry_r   <= '0;
      is_halt_r <= 1'b0;
    end else if (load) begin
      entry_r   <= wr_entry;
      is_halt_r <= wr_is_halt;
    end else begin
      entry_r   <= entry_r;
      is_halt_r <= is_halt_r;
    end
  end

  assign entry   = entry_r;
  assign is_halt = is_halt_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the icache request and PC update, owns the
// IF/ID register, absorbs decode stalls and handles redirects and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t HALT_WORD = HALT_INSTR
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] curr_pc,
  input  logic [31:0] npc,
  output logic        pc_en,
  output logic [31:0] pc_new_pc,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  output logic        halted
);

  fetch_state_t state_r, state_s;
  fetch_latch_t if_latch_r, if_latch_s;
  fetch_latch_t fetch_word_s, hold_entry_s;
  word_t        pending_pc_r, pending_pc_s;
  logic         out_ready_s, is_halt_s;
  logic         hold_load_s, hold_drain_s, hold_clear_s, hold_is_halt_s;

  assign out_ready_s  = ~if_latch_r.valid | ~id_stall;
  assign is_halt_s    = (iload == HALT_WORD);
  assign fetch_word_s = '{valid: 1'b1, instr: iload, pc: curr_pc, npc: npc};

  fetch_hold_buf u_hold_buf (
    .CLK        (CLK),
    .nRST       (nRST),
    .load       (hold_load_s),
    .drain      (hold_drain_s),
    .clear      (hold_clear_s),
    .wr_entry   (fetch_word_s),
    .wr_is_halt (is_halt_s),
    .entry      (hold_entry_s),
    .is_halt    (hold_is_halt_s)
  );

  // State, redirect target and IF/ID register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= FETCH;
      pending_pc_r <= 32'h0000_0000;
      if_latch_r   <= '0;
    end else begin
      state_r      <= state_s;
      pending_pc_r <= pending_pc_s;
      if_latch_r   <= if_latch_s;
    end
  end

  // Next state, PC control, icache request and IF/ID update.
  always_comb begin
    state_s      = state_r;
    pending_pc_s = pending_pc_r;
    pc_en        = 1'b0;
    pc_new_pc    = 32'h0000_0000;
    iREN         = 1'b0;
    iaddr        = 32'h0000_0000;
    hold_load_s  = 1'b0;
    hold_drain_s = 1'b0;
    hold_clear_s = 1'b0;
    if_latch_s   = if_latch_r;
    // A redirect always kills IF/ID; an accepting consumer with no new data sees a bubble.
    if (redirect || out_ready_s) begin
      if_latch_s.valid = 1'b0;
    end else begin
      if_latch_s = if_latch_r;
    end

    case (state_r)
      FETCH: begin
        iREN  = 1'b1;
        iaddr = curr_pc;
        if (ihit) begin
          if (redirect) begin
            pc_en     = 1'b1;
            pc_new_pc = redirect_pc;
          end else begin
            pc_en     = ~is_halt_s;
            pc_new_pc = is_halt_s ? 32'h0000_0000 : npc;
            if (out_ready_s) begin
              if_latch_s = fetch_word_s;
              state_s    = is_halt_s ? HALTED : FETCH;
            end else begin
              hold_load_s = 1'b1;
              state_s     = HOLD;
            end
          end
        end else if (redirect) begin
          // The outstanding request must complete before the PC can move.
          pending_pc_s = redirect_pc;
          state_s      = SQUASH;
        end else begin
          state_s = FETCH;
        end
      end
      SQUASH: begin
        iREN  = 1'b1;
        iaddr = curr_pc;
        if (ihit) begin
          pc_en     = 1'b1;
          pc_new_pc = redirect ? redirect_pc : pending_pc_r;
          state_s   = FETCH;
        end else if (redirect) begin
          pending_pc_s = redirect_pc;
        end else begin
          state_s = SQUASH;
        end
      end
      HOLD: begin
        if (redirect) begin
          hold_clear_s = 1'b1;
          pc_en        = 1'b1;
          pc_new_pc    = redirect_pc;
          state_s      = FETCH;
        end else if (out_ready_s) begin
          if_latch_s   = hold_entry_s;
          hold_drain_s = 1'b1;
          state_s      = hold_is_halt_s ? HALTED : FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      HALTED: begin
        if (redirect) begin
          pc_en     = 1'b1;
          pc_new_pc = redirect_pc;
          state_s   = FETCH;
        end else begin
          state_s = HALTED;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
  end

  assign if_valid = if_latch_r.valid;
  assign if_instr = if_latch_r.instr;
  assign if_pc    = if_latch_r.pc;
  assign if_npc   = if_latch_r.npc;
  assign halted   = (state_r == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        CLK, nRST;
  logic [31:0] curr_pc, npc, pc_new_pc, iaddr, iload, redirect_pc;
  logic [31:0] if_instr, if_pc, if_npc;
  logic        pc_en, iREN, ihit, id_stall, redirect, if_valid, halted;

  fetch_unit dut (
    .CLK(CLK), .nRST(nRST), .curr_pc(curr_pc), .npc(npc),
    .pc_en(pc_en), .pc_new_pc(pc_new_pc), .iREN(iREN), .iaddr(iaddr),
    .ihit(ihit), .iload(iload), .id_stall(id_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_npc(if_npc), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    bit          halt;
  } hold_t;

  // Model: program counter, IF/ID contents, parked words, redirect in flight, stopped flag.
  logic [31:0] pc_m;
  bit          m_v;
  logic [31:0] m_i, m_p, m_n;
  hold_t       hq[$];
  bit          m_sq;
  logic [31:0] m_sq_pc;
  bit          stopped;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pc_m = 32'h0; m_v = 1'b0; m_i = 32'h0; m_p = 32'h0; m_n = 32'h0;
    hq.delete(); m_sq = 1'b0; m_sq_pc = 32'h0; stopped = 1'b0;
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the model.
  task automatic step(input bit h, input logic [31:0] w, input bit st,
                      input bit rd, input logic [31:0] rp);
    bit          fresh, is_h, out_rdy, e_iren, e_pcen;
    logic [31:0] e_tgt;
    hold_t       e;
    @(negedge CLK);
    curr_pc = pc_m; npc = pc_m + 32'd4;
    ihit = h; iload = w; id_stall = st; redirect = rd; redirect_pc = rp;
    #1;
    is_h    = (w == 32'hFFFF_FFFF);
    fresh   = !stopped && hq.size() == 0 && !m_sq;
    out_rdy = !m_v || !st;
    e_iren  = !stopped && hq.size() == 0;
    e_pcen  = 1'b0; e_tgt = 32'h0;
    if (stopped || hq.size() != 0) begin
      e_pcen = rd; e_tgt = rd ? rp : 32'h0;
    end else if (m_sq) begin
      e_pcen = h; e_tgt = h ? (rd ? rp : m_sq_pc) : 32'h0;
    end else if (h) begin
      e_pcen = rd || !is_h; e_tgt = rd ? rp : (is_h ? 32'h0 : pc_m + 32'd4);
    end
    check("iREN", {31'd0, iREN}, {31'd0, e_iren});
    check("iaddr", iaddr, e_iren ? pc_m : 32'h0);
    check("pc_en", {31'd0, pc_en}, {31'd0, e_pcen});
    check("pc_new_pc", pc_new_pc, e_tgt);
    check("halted", {31'd0, halted}, {31'd0, stopped});
    check("if_valid", {31'd0, if_valid}, {31'd0, m_v});
    check("if_instr", if_instr, m_i);
    check("if_pc", if_pc, m_p);
    check("if_npc", if_npc, m_n);

    if (fresh) begin
      if (rd) m_v = 1'b0;
      else if (h) begin
        if (out_rdy) begin
          m_v = 1'b1; m_i = w; m_p = pc_m; m_n = pc_m + 32'd4;
          if (is_h) stopped = 1'b1;
        end else hq.push_back('{w, pc_m, pc_m + 32'd4, is_h});
      end else if (out_rdy) m_v = 1'b0;
      if (!h && rd) begin m_sq = 1'b1; m_sq_pc = rp; end
    end else if (hq.size() != 0) begin
      if (rd) begin hq.delete(); m_v = 1'b0; end
      else if (out_rdy) begin
        e = hq.pop_front();
        m_v = 1'b1; m_i = e.instr; m_p = e.pc; m_n = e.npc;
        if (e.halt) stopped = 1'b1;
      end
    end else if (m_sq) begin
      if (rd || out_rdy) m_v = 1'b0;
      if (h) m_sq = 1'b0;
      else if (rd) m_sq_pc = rp;
    end else begin
      if (rd) begin m_v = 1'b0; stopped = 1'b0; end
      else if (out_rdy) m_v = 1'b0;
    end
    if (e_pcen) pc_m = e_tgt;
  endtask

  initial begin
    model_reset();
    nRST = 1'b0; curr_pc = 32'h0; npc = 32'h4; ihit = 1'b0; iload = 32'h0;
    id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #12;
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_iREN", {31'd0, iREN}, 32'd1);
    @(negedge CLK); nRST = 1'b1;

    // Plain hit after reset release.
    step(1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    check("t1_instr", if_instr, 32'h2001_0005);
    check("t1_pc", if_pc, 32'h0);

    // Three misses then a hit: request held, PC frozen.
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);

    // Stall with a hit parks the word in the hold buffer.
    step(1'b1, 32'h8C22_0000, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("t3_pc", pc_m, 32'hC);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    check("t3_instr", if_instr, 32'h8C22_0000);
    check("t3_pc_out", if_pc, 32'h8);

    // Redirect during a miss: old request completes, data dropped.
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    check("t4_valid", {31'd0, if_valid}, 32'd0);
    check("t4_pc", pc_m, 32'h40);

    // Halt, then restart via redirect.
    step(1'b1, 32'h0, 1'b0, 1'b1, 32'h20);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    check("t5_halted", {31'd0, halted}, 32'd1);
    check("t5_instr", if_instr, 32'hFFFF_FFFF);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    @(posedge CLK); #1;
    check("t5_restart", {31'd0, halted}, 32'd0);
    check("t5_pc", pc_m, 32'h100);

    // Asynchronous reset while holding.
    step(1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0000_0022, 1'b1, 1'b0, 32'h0);
    @(negedge CLK); #2;
    nRST = 1'b0; ihit = 1'b0; redirect = 1'b0;
    #1;
    check("t6_valid", {31'd0, if_valid}, 32'd0);
    check("t6_iREN", {31'd0, iREN}, 32'd1);
    model_reset();
    @(negedge CLK); nRST = 1'b1;
    step(1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : $urandom;
      step($urandom_range(0, 2) != 0, w, $urandom_range(0, 4) < 2,
           $urandom_range(0, 7) == 0, {$urandom_range(0, 1023), 2'b00});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage. Sits between program_counter and the IF/ID latch consumer (decode).
- Takes curr_pc/npc from the program counter and drives its en/new_pc.
- Issues word reads to the instruction cache.
- Registers fetched instructions for decode.
- Absorbs decode stalls with a one-entry hold buffer and handles execute-stage redirects and halt.

Parameters:
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch
WORD_W, 32, width of word_t (fixed by cpu_types_pkg; documentation only)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
curr_pc  in  32  current PC from program_counter
npc  in  32  curr_pc+4 from program_counter
pc_en  out  1  program_counter update enable
pc_new_pc  out  32  next PC value to program_counter
iREN  out  1  icache read request
iaddr  out  32  icache address
ihit  in  1  icache data valid this cycle
iload  in  32  icache read data
id_stall  in  1  decode cannot accept; hold IF/ID
redirect  in  1  branch/jump resolved taken in execute
redirect_pc  in  32  redirect target
if_valid  out  1  IF/ID entry valid
if_instr  out  32  IF/ID instruction
if_pc  out  32  IF/ID instruction PC
if_npc  out  32  IF/ID PC+4
halted  out  1  fetch stopped on HALT_WORD

Behaviour:
- Reset (async, nRST=0):
  - state=FETCH.
  - if_valid/if_instr/if_pc/if_npc=0; hold buffer cleared; pending_pc=0.
  - halted=0.
  - Combinational outputs follow state immediately.
- Signal definitions:
  - out_ready = ~if_valid | ~id_stall.
  - iaddr = curr_pc in FETCH and SQUASH, else 0.
  - iREN = 1 in FETCH and SQUASH.
- Request rule: once iREN rises it stays high with a stable iaddr until ihit. The PC must not change while a request is outstanding.
- States:
  - FETCH:
    - ihit & ~redirect & iload!=HALT_WORD: pc_en=1, pc_new_pc=npc. If out_ready, load IF/ID {1,iload,curr_pc,npc}, stay in FETCH. Else write the hold buffer and go to HOLD.
    - ihit & iload==HALT_WORD (no redirect): pc_en=0. Load IF/ID, or the hold buffer if ~out_ready. Go to HALTED, or to HOLD with hold_is_halt=1.
    - redirect & ihit: discard data, pc_en=1, pc_new_pc=redirect_pc, stay in FETCH.
    - redirect & ~ihit: pending_pc<=redirect_pc, go to SQUASH, keep the request.
  - SQUASH:
    - Keep requesting curr_pc.
    - On ihit: discard, pc_en=1, pc_new_pc=pending_pc (or redirect_pc if redirect is also high this cycle), go to FETCH.
    - A redirect without ihit overwrites pending_pc.
  - HOLD:
    - iREN=0.
    - When out_ready: move buffer to IF/ID, go to FETCH (or HALTED if hold_is_halt).
    - redirect: drop buffer, pc_en=1, pc_new_pc=redirect_pc, go to FETCH.
  - HALTED:
    - iREN=0, pc_en=0, halted=1.
    - redirect: pc_en=1, pc_new_pc=redirect_pc, halted=0, go to FETCH.
- IF/ID register priority, per cycle:
  - redirect -> if_valid=0, regardless of id_stall.
  - else if out_ready -> load new data if available (FETCH ihit or HOLD drain), else if_valid=0.
  - else hold.
- pc_en is never asserted outside the cases above. pc_new_pc=0 whenever pc_en=0.
- Latency: ihit in cycle N -> if_valid in N+1 (no stall). PC update is also visible in N+1.
- Reset asserted mid-request: all state cleared asynchronously; a late ihit after release is treated as a fresh FETCH hit.

Decomposition:
- cpu_types_pkg additions:
  - fetch_state_t enum {FETCH, SQUASH, HOLD, HALTED}.
  - fetch_latch_t struct {valid, instr, pc, npc}.
  - HALT_INSTR constant.
- One natural sub-module: fetch_hold_buf. One-entry buffer holding fetch_latch_t plus is_halt, with load/drain/clear controls.
- Top contains the FSM and the IF/ID register.

Test Plan:
1. Reset release, curr_pc=0x0, npc=0x4, ihit=1, iload=0x20010005, no stall -> iREN=1 and iaddr=0x0 the cycle after release; pc_en=1, pc_new_pc=0x4; next cycle if_valid=1, if_instr=0x20010005, if_pc=0x0, if_npc=0x4.
2. ihit held low 3 cycles then high -> iREN high and iaddr stable for 4 cycles; pc_en only in the 4th.
3. if_valid=1, id_stall=1, ihit with iload=0x8C220000 at pc 0x8 -> state HOLD, PC advanced to 0xC, iREN=0. Drop id_stall -> IF/ID shows 0x8C220000/0x8 next cycle, iREN re-asserts.
4. Redirect to 0x40 during miss at 0x10 -> SQUASH. Request 0x10 held until ihit; that data is discarded; pc_new_pc=0x40; if_valid=0.
5. iload=0xFFFFFFFF at 0x20 -> IF/ID valid with halt, halted=1, iREN=0, pc_en=0. Later redirect to 0x100 -> halted=0, pc_new_pc=0x100.
6. nRST pulsed low mid-HOLD -> if_valid=0 and state FETCH immediately, without waiting for a clock edge.
